// File: rtl/lc3_execute_pkg.sv
// Shared types for the LC3 execute stage: opcodes, E_Control field layout.
// Optional feature macro: LC3_EXECUTE_OUT_VALID_EN (see lc3_execute_stage).
package lc3_execute_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_ZERO = 2'b11
    } e_alu_t;

    typedef enum logic [1:0] {
        PC_OFF11 = 2'b00,
        PC_OFF9  = 2'b01,
        PC_OFF6  = 2'b10,
        PC_ZERO  = 2'b11
    } e_pcsel1_t;

    typedef struct packed {
        e_alu_t    alu_control;
        e_pcsel1_t pcselect1;
        logic      pcselect2;
        logic      op2select;
    } e_control_t;

endpackage

// File: rtl/lc3_execute_alu.sv
// Combinational LC3 ALU: ADD / AND / NOT, code 11 yields zero.
module lc3_execute_alu
    import lc3_execute_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_val1,
    input  logic [DATA_W-1:0] i_op2,
    input  e_alu_t            i_ctrl,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        unique case (i_ctrl)
            ALU_ADD:  o_result = i_val1 + i_op2;
            ALU_AND:  o_result = i_val1 & i_op2;
            ALU_NOT:  o_result = ~i_val1;
            ALU_ZERO: o_result = '0;
        endcase
    end

endmodule

// File: rtl/lc3_execute_stage.sv
// LC3 execute stage: operand bypass, ALU, address generation, registered bundle.
// Optional macro LC3_EXECUTE_OUT_VALID_EN adds the out_valid output.
module lc3_execute_stage
    import lc3_execute_pkg::*;
#(
    parameter int              DATA_W        = 16,
    parameter logic [DATA_W-1:0] OUT_RESET_VAL = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_execute,
    input  logic              Mem_Control_in,
    input  logic [1:0]        W_Control_in,
    input  logic [5:0]        E_Control,
    input  logic [DATA_W-1:0] IR,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [DATA_W-1:0] VSR1,
    input  logic [DATA_W-1:0] VSR2,
    input  logic              bypass_alu_1,
    input  logic              bypass_alu_2,
    input  logic              bypass_mem_1,
    input  logic              bypass_mem_2,
    input  logic [DATA_W-1:0] Mem_Bypass_Val,
    output logic [DATA_W-1:0] aluout,
    output logic [DATA_W-1:0] pcout,
    output logic [2:0]        dr,
    output logic [DATA_W-1:0] IR_Exec,
    output logic [2:0]        NZP,
    output logic [1:0]        W_Control_out,
    output logic              Mem_Control_out,
    output logic [DATA_W-1:0] M_Data,
`ifdef LC3_EXECUTE_OUT_VALID_EN
    output logic              out_valid,
`endif
    output logic [2:0]        sr1,
    output logic [2:0]        sr2
);

    if (DATA_W != 16) begin : g_bad_width
        $error("lc3_execute_stage supports DATA_W=16 only");
    end

    e_control_t        w_ctrl;
    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_val1;
    logic [DATA_W-1:0] w_val2;
    logic [DATA_W-1:0] w_op2;
    logic [DATA_W-1:0] w_alu_res;
    logic [DATA_W-1:0] w_off;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_pc;
    logic              w_is_alu;

    assign w_ctrl = e_control_t'(E_Control);
    assign w_op   = IR[15:12];

    assign sr1 = IR[8:6];
    assign sr2 = (w_op == OP_ST || w_op == OP_STR || w_op == OP_STI)
               ? IR[11:9] : IR[2:0];

    // ALU bypass outranks memory bypass: it carries the younger result
    assign w_val1 = bypass_alu_1 ? aluout
                  : bypass_mem_1 ? Mem_Bypass_Val : VSR1;
    assign w_val2 = bypass_alu_2 ? aluout
                  : bypass_mem_2 ? Mem_Bypass_Val : VSR2;

    assign w_op2 = w_ctrl.op2select ? w_val2
                 : {{(DATA_W-5){IR[4]}}, IR[4:0]};

    lc3_execute_alu #(.DATA_W(DATA_W)) u_alu (
        .i_val1   (w_val1),
        .i_op2    (w_op2),
        .i_ctrl   (w_ctrl.alu_control),
        .o_result (w_alu_res)
    );

    always_comb begin
        w_off = '0;
        unique case (w_ctrl.pcselect1)
            PC_OFF11: w_off = {{(DATA_W-11){IR[10]}}, IR[10:0]};
            PC_OFF9:  w_off = {{(DATA_W-9){IR[8]}}, IR[8:0]};
            PC_OFF6:  w_off = {{(DATA_W-6){IR[5]}}, IR[5:0]};
            PC_ZERO:  w_off = '0;
        endcase
    end

    assign w_base   = w_ctrl.pcselect2 ? npc_in : w_val1;
    assign w_pc     = w_base + w_off;
    assign w_is_alu = (w_op == OP_ADD || w_op == OP_AND || w_op == OP_NOT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout          <= OUT_RESET_VAL;
            pcout           <= OUT_RESET_VAL;
            M_Data          <= OUT_RESET_VAL;
            dr              <= '0;
            NZP             <= '0;
            IR_Exec         <= '0;
            W_Control_out   <= '0;
            Mem_Control_out <= 1'b0;
        end else if (enable_execute) begin
            aluout          <= w_is_alu ? w_alu_res : w_pc;
            pcout           <= w_pc;
            M_Data          <= w_val2;
            dr              <= IR[11:9];
            NZP             <= (w_op == OP_BR) ? IR[11:9] : 3'b000;
            IR_Exec         <= IR;
            W_Control_out   <= W_Control_in;
            Mem_Control_out <= Mem_Control_in;
        end
    end

`ifdef LC3_EXECUTE_OUT_VALID_EN
    logic r_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_valid <= 1'b0;
        else        r_valid <= enable_execute;
    end

    assign out_valid = r_valid;
`endif

endmodule

// File: tb/tb_lc3_execute_stage.sv
// Scoreboard bench for lc3_execute_stage: directed vectors, queued expectations.
module tb_lc3_execute_stage;
    import lc3_execute_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_execute = 1'b0;
    logic        Mem_Control_in = 1'b0;
    logic [1:0]  W_Control_in = 2'b00;
    logic [5:0]  E_Control = '0;
    logic [15:0] IR = '0, npc_in = '0, VSR1 = '0, VSR2 = '0;
    logic        bypass_alu_1 = 0, bypass_alu_2 = 0;
    logic        bypass_mem_1 = 0, bypass_mem_2 = 0;
    logic [15:0] Mem_Bypass_Val = '0;
    logic [15:0] aluout, pcout, IR_Exec, M_Data;
    logic [2:0]  dr, NZP, sr1, sr2;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;
`ifdef LC3_EXECUTE_OUT_VALID_EN
    logic        out_valid;
`endif

    lc3_execute_stage dut (
        .clock           (clock),
        .reset           (reset),
        .enable_execute  (enable_execute),
        .Mem_Control_in  (Mem_Control_in),
        .W_Control_in    (W_Control_in),
        .E_Control       (E_Control),
        .IR              (IR),
        .npc_in          (npc_in),
        .VSR1            (VSR1),
        .VSR2            (VSR2),
        .bypass_alu_1    (bypass_alu_1),
        .bypass_alu_2    (bypass_alu_2),
        .bypass_mem_1    (bypass_mem_1),
        .bypass_mem_2    (bypass_mem_2),
        .Mem_Bypass_Val  (Mem_Bypass_Val),
        .aluout          (aluout),
        .pcout           (pcout),
        .dr              (dr),
        .IR_Exec         (IR_Exec),
        .NZP             (NZP),
        .W_Control_out   (W_Control_out),
        .Mem_Control_out (Mem_Control_out),
        .M_Data          (M_Data),
`ifdef LC3_EXECUTE_OUT_VALID_EN
        .out_valid       (out_valid),
`endif
        .sr1             (sr1),
        .sr2             (sr2)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          tgt;
        logic [15:0] alu, pc, md, ir;
        logic [2:0]  dr, nzp;
        logic [1:0]  wc;
        logic        mc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0 && q[0].tgt <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("aluout", aluout, e.alu);
            chk("pcout", pcout, e.pc);
            chk("M_Data", M_Data, e.md);
            chk("IR_Exec", IR_Exec, e.ir);
            chk("dr", {13'd0, dr}, {13'd0, e.dr});
            chk("NZP", {13'd0, NZP}, {13'd0, e.nzp});
            chk("W_Control_out", {14'd0, W_Control_out}, {14'd0, e.wc});
            chk("Mem_Control_out", {15'd0, Mem_Control_out}, {15'd0, e.mc});
        end
    end

    task automatic issue(input logic [15:0] ir, input logic [5:0] ctrl,
                         input logic [15:0] npc, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [3:0] byp,
                         input logic [15:0] mbv, input logic en,
                         input logic [15:0] ealu, input logic [15:0] epc,
                         input logic [15:0] emd, input logic [2:0] enzp,
                         input logic [2:0] esr1, input logic [2:0] esr2);
        exp_t e;
        @(posedge clock);
        #1;
        IR = ir;
        E_Control = ctrl;
        npc_in = npc;
        VSR1 = v1;
        VSR2 = v2;
        {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = byp;
        Mem_Bypass_Val = mbv;
        W_Control_in = W_Control_in + 2'd1;
        Mem_Control_in = ~Mem_Control_in;
        enable_execute = en;
        if (en) begin
            e.alu = ealu;
            e.pc  = epc;
            e.md  = emd;
            e.ir  = ir;
            e.dr  = ir[11:9];
            e.nzp = enzp;
            e.wc  = W_Control_in;
            e.mc  = Mem_Control_in;
            last  = e;
        end else begin
            e = last;
        end
        e.tgt = cyc + 1;
        q.push_back(e);
        #1;
        chk("sr1", {13'd0, sr1}, {13'd0, esr1});
        chk("sr2", {13'd0, sr2}, {13'd0, esr2});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " aluout"}, aluout, 16'h0000);
        chk({tag, " pcout"}, pcout, 16'h0000);
        chk({tag, " M_Data"}, M_Data, 16'h0000);
        chk({tag, " IR_Exec"}, IR_Exec, 16'h0000);
        chk({tag, " dr"}, {13'd0, dr}, 16'h0000);
        chk({tag, " NZP"}, {13'd0, NZP}, 16'h0000);
        chk({tag, " W_Control_out"}, {14'd0, W_Control_out}, 16'h0000);
        chk({tag, " Mem_Control_out"}, {15'd0, Mem_Control_out}, 16'h0000);
    endtask

    initial begin
        repeat (3000) @(posedge clock);
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        last = '{tgt: 0, alu: 16'h0, pc: 16'h0, md: 16'h0, ir: 16'h0,
                 dr: 3'd0, nzp: 3'd0, wc: 2'd0, mc: 1'b0};
        #2;
        chk_reset("reset0");
        @(negedge clock);
        reset = 1'b1;

        // ir, ctrl, npc, vsr1, vsr2, {ba1,bm1,ba2,bm2}, mbv, en,
        // exp aluout, pcout, M_Data, NZP, sr1, sr2
        issue(16'h1261, 6'h00, 16'h0000, 16'h7FFF, 16'h1111, 4'b0000,
              16'h0000, 1, 16'h8000, 16'h8260, 16'h1111, 3'd0, 3'd1, 3'd1);
        issue(16'h1425, 6'h00, 16'h0000, 16'h0000, 16'h2222, 4'b0000,
              16'h0000, 1, 16'h0005, 16'hFC25, 16'h2222, 3'd0, 3'd0, 3'd5);
        issue(16'h5263, 6'h10, 16'h0000, 16'hFFFF, 16'h3333, 4'b1100,
              16'h0009, 1, 16'h0001, 16'h0268, 16'h3333, 3'd0, 3'd1, 3'd3);
        issue(16'h1842, 6'h01, 16'h0000, 16'h0020, 16'hDEAD, 4'b0001,
              16'h0100, 1, 16'h0120, 16'h0062, 16'h0100, 3'd0, 3'd1, 3'd2);
        issue(16'h967F, 6'h20, 16'h0000, 16'h00FF, 16'h4444, 4'b0000,
              16'h0000, 1, 16'hFF00, 16'hFF7E, 16'h4444, 3'd0, 3'd1, 3'd7);
        issue(16'h1261, 6'h30, 16'h0000, 16'h1234, 16'h0000, 4'b0000,
              16'h0000, 1, 16'h0000, 16'h1495, 16'h0000, 3'd0, 3'd1, 3'd1);
        issue(16'h0E02, 6'h06, 16'h3001, 16'h0000, 16'h5555, 4'b0000,
              16'h0000, 1, 16'h3003, 16'h3003, 16'h5555, 3'd7, 3'd0, 3'd2);
        // stall: outputs hold, sr1/sr2 keep following IR
        issue(16'h3A55, 6'h3F, 16'h9999, 16'h8888, 16'h7777, 4'b1111,
              16'h6666, 0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd1, 3'd5);
        issue(16'h1FFF, 6'h01, 16'h1234, 16'h4321, 16'h0F0F, 4'b0000,
              16'hAAAA, 0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd7, 3'd7);
        issue(16'h7E00, 6'h0C, 16'hFFFF, 16'h0001, 16'hF0F0, 4'b0101,
              16'h5A5A, 0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd7);
        // resume: ALU bypass sees the held 3003
        issue(16'h1021, 6'h00, 16'h0000, 16'h0000, 16'h0000, 4'b1000,
              16'h0000, 1, 16'h3004, 16'h3024, 16'h0000, 3'd0, 3'd0, 3'd1);
        issue(16'h3602, 6'h06, 16'hFFFF, 16'h1111, 16'hABCD, 4'b0000,
              16'h0000, 1, 16'h0001, 16'h0001, 16'hABCD, 3'd0, 3'd0, 3'd3);
        issue(16'hB401, 6'h06, 16'h1000, 16'h0000, 16'h2222, 4'b0000,
              16'h0000, 1, 16'h1001, 16'h1001, 16'h2222, 3'd0, 3'd0, 3'd2);
        issue(16'h7A40, 6'h08, 16'h0000, 16'h0200, 16'h0000, 4'b0011,
              16'h7777, 1, 16'h0200, 16'h0200, 16'h1001, 3'd0, 3'd1, 3'd5);
        issue(16'h6283, 6'h08, 16'h0000, 16'h4000, 16'h3C3C, 4'b0000,
              16'h0000, 1, 16'h4003, 16'h4003, 16'h3C3C, 3'd0, 3'd2, 3'd3);
        issue(16'hC1C0, 6'h0C, 16'h5000, 16'h2468, 16'h0000, 4'b0000,
              16'h0000, 1, 16'h2468, 16'h2468, 16'h0000, 3'd0, 3'd7, 3'd0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
            q.delete();
        end

        // asynchronous reset between edges, then an edge with enable high
        @(posedge clock);
        #3;
        IR = 16'h1261;
        VSR1 = 16'h7FFF;
        E_Control = 6'h00;
        enable_execute = 1'b1;
        reset = 1'b0;
        #1;
        chk_reset("async_reset");
        @(posedge clock);
        #1;
        chk_reset("reset_hold");
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
